// File: rtl/dspl_pkg.sv
// Shared constants for the multiplexed display: character codes, the
// active-low segment patterns {a,b,c,d,e,f,g}, and the per-digit field layout.
package dspl_pkg;

  // Character codes above the decimal digits
  localparam logic [4:0] CH_P     = 5'h0A;
  localparam logic [4:0] CH_B     = 5'h0B;
  localparam logic [4:0] CH_C     = 5'h0C;
  localparam logic [4:0] CH_R     = 5'h0D;
  localparam logic [4:0] CH_E     = 5'h0E;
  localparam logic [4:0] CH_S     = 5'h0F;
  localparam logic [4:0] CH_U     = 5'h10;
  localparam logic [4:0] CH_G     = 5'h11;
  localparam logic [4:0] CH_BLANK = 5'h12;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b1110010;
  localparam logic [6:0] SEG_R     = 7'b1111010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_G     = 7'b0100000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One digit's 7-bit field as it appears on the digits bus
  typedef struct packed {
    logic       en;
    logic [4:0] chr;
    logic       dp;
  } dig_fld_t;

endpackage

// File: rtl/dspl_seg_dec.sv
// Character-code to active-low seven-segment decoder (purely combinational).
module dspl_seg_dec
  import dspl_pkg::*;
(
  input  logic [4:0] chr,
  output logic [6:0] seg
);

  // Map each character code to its segment pattern; unused codes are blank
  always_comb begin
    seg = SEG_BLANK;
    case (chr)
      5'd0:     seg = SEG_0;
      5'd1:     seg = SEG_1;
      5'd2:     seg = SEG_2;
      5'd3:     seg = SEG_3;
      5'd4:     seg = SEG_4;
      5'd5:     seg = SEG_5;
      5'd6:     seg = SEG_6;
      5'd7:     seg = SEG_7;
      5'd8:     seg = SEG_8;
      5'd9:     seg = SEG_9;
      CH_P:     seg = SEG_P;
      CH_B:     seg = SEG_B;
      CH_C:     seg = SEG_C;
      CH_R:     seg = SEG_R;
      CH_E:     seg = SEG_E;
      CH_S:     seg = SEG_S;
      CH_U:     seg = SEG_U;
      CH_G:     seg = SEG_G;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dspl_mux_pwm.sv
// Multiplexed seven-segment display driver with 16-phase PWM brightness
// and per-digit blink. One clock domain; the phase tick is an enable only.
module dspl_mux_pwm
  import dspl_pkg::*;
#(
  parameter int NUM_DIG          = 8,
  parameter int PHASE_COUNT      = 3125,
  parameter int BLINK_HALF_SCANS = 250
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7*NUM_DIG-1:0] digits,
  input  logic [NUM_DIG-1:0]   blink,
  input  logic [3:0]           bright,
  output logic [NUM_DIG-1:0]   an,
  output logic [6:0]           seg,
  output logic                 dp_n
);

  localparam int PRE_W = (PHASE_COUNT > 1) ? $clog2(PHASE_COUNT) : 1;
  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int SCN_W = (BLINK_HALF_SCANS > 1) ? $clog2(BLINK_HALF_SCANS) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic             phase_tick;
  logic [3:0]       phase;
  logic             slot_end;

  // nxt_idx is the digit the next boundary will latch; cur_idx is the one shown
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             primed;

  dig_fld_t         fld_sel;
  logic             blink_sel;

  dig_fld_t         fld_p0;
  logic             blink_p0;
  logic [3:0]       bright_p0;

  logic [SCN_W-1:0] scan_cnt;
  logic             blink_off;
  logic             scan_done;

  logic             lit_p0;
  logic [6:0]       seg_dec;
  logic [NUM_DIG-1:0] an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  assign phase_tick = (pre_cnt == PRE_W'(PHASE_COUNT - 1));
  assign slot_end   = phase_tick && (phase == 4'd15);
  // The boundary that brings digit 0 back (but not the very first latch) ends a scan
  assign scan_done  = slot_end && primed && (nxt_idx == '0);

  // Phase prescaler: free-running 0..PHASE_COUNT-1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (phase_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // PWM phase counter, wraps 15 -> 0 at each slot boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= 4'd0;
    end else if (phase_tick) begin
      phase <= phase + 4'd1;
    end
  end

  // Pick the field and blink bit of the digit about to be latched
  always_comb begin
    fld_sel   = '0;
    blink_sel = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (nxt_idx == IDX_W'(i)) begin
        fld_sel   = dig_fld_t'(digits[7*i +: 7]);
        blink_sel = blink[i];
      end
    end
  end

  // Stage p0: digit index advance and per-slot latch of field, blink and brightness
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_idx   <= '0;
      nxt_idx   <= '0;
      primed    <= 1'b0;
      fld_p0    <= '0;
      blink_p0  <= 1'b0;
      bright_p0 <= 4'd0;
    end else if (slot_end) begin
      cur_idx   <= nxt_idx;
      nxt_idx   <= (nxt_idx == IDX_W'(NUM_DIG - 1)) ? '0 : nxt_idx + IDX_W'(1);
      primed    <= 1'b1;
      fld_p0    <= fld_sel;
      blink_p0  <= blink_sel;
      bright_p0 <= bright;
    end
  end

  // Scan counter: toggles the blink phase every BLINK_HALF_SCANS completed scans
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      blink_off <= 1'b0;
    end else if (scan_done) begin
      if (scan_cnt == SCN_W'(BLINK_HALF_SCANS - 1)) begin
        scan_cnt  <= '0;
        blink_off <= ~blink_off;
      end else begin
        scan_cnt <= scan_cnt + SCN_W'(1);
      end
    end
  end

  dspl_seg_dec u_seg_dec (
    .chr (fld_p0.chr),
    .seg (seg_dec)
  );

  // Lit decision and next output values; everything blanks together when dark
  always_comb begin
    lit_p0  = fld_p0.en && (phase < bright_p0) && !(blink_p0 && blink_off);
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (lit_p0) begin
      an_nxt  = ~(NUM_DIG'(1) << cur_idx);
      seg_nxt = seg_dec;
      dp_nxt  = ~fld_p0.dp;
    end
  end

  // Stage p1: registered outputs, all updated on the same edge so digits never ghost
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an   <= '1;
      seg  <= SEG_BLANK;
      dp_n <= 1'b1;
    end else begin
      an   <= an_nxt;
      seg  <= seg_nxt;
      dp_n <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_dspl_mux_pwm.sv
// Directed bench for dspl_mux_pwm with 4 digits, 2-cycle phases, 2-scan blink.
// A slot lasts 32 clocks; output samples lag the internal state by one clock.
module tb_dspl_mux_pwm;

  localparam int ND = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7*ND-1:0] digits = '0;
  logic [ND-1:0]   blink  = '0;
  logic [3:0]      bright = 4'd0;
  logic [ND-1:0]   an;
  logic [6:0]      seg;
  logic            dp_n;

  int cyc;
  int nerr = 0;
  int nchk = 0;

  typedef struct {
    int         slot;
    int         ph;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } vec_t;

  vec_t tab[15];

  dspl_mux_pwm #(
    .NUM_DIG          (ND),
    .PHASE_COUNT      (2),
    .BLINK_HALF_SCANS (2)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .digits (digits),
    .blink  (blink),
    .bright (bright),
    .an     (an),
    .seg    (seg),
    .dp_n   (dp_n)
  );

  always #5 clock = ~clock;

  // Clocks since reset release; edge n leaves the DUT in the state of cycle n
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [6:0] fld(input logic en, input logic [4:0] c, input logic d);
    return {en, c, d};
  endfunction

  task automatic chk(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    nchk++;
    if (an !== ea || seg !== es || dp_n !== ed) begin
      nerr++;
      $display("FAIL %s: got an=%b seg=%b dp_n=%b, want an=%b seg=%b dp_n=%b",
               name, an, seg, dp_n, ea, es, ed);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  // Move to the sample point showing phase ph of slot s (slot 0 = first, blank slot)
  task automatic at(input int s, input int ph);
    int n;
    n = 32*s + 2*ph + 2;
    if (cyc > n) begin
      nerr++;
      $display("FAIL sequencing: at cycle %0d, wanted %0d", cyc, n);
    end
    wait_cyc(n);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tab[0]  = '{0,  5,  4'b1111, 7'b1111111, 1'b1, "first_slot_blank"};
    tab[1]  = '{1,  0,  4'b1110, 7'b1001111, 1'b1, "dig0_char1"};
    tab[2]  = '{1,  14, 4'b1110, 7'b1001111, 1'b1, "dig0_ph14_lit"};
    tab[3]  = '{1,  15, 4'b1111, 7'b1111111, 1'b1, "dig0_ph15_dark"};
    tab[4]  = '{2,  0,  4'b1101, 7'b0010010, 1'b1, "dig1_char2"};
    tab[5]  = '{3,  7,  4'b1011, 7'b0000110, 1'b1, "dig2_char3"};
    tab[6]  = '{4,  0,  4'b0111, 7'b1001100, 1'b1, "dig3_char4"};
    tab[7]  = '{4,  15, 4'b1111, 7'b1111111, 1'b1, "dig3_ph15_dark"};
    tab[8]  = '{5,  0,  4'b1110, 7'b1001111, 1'b1, "scan1_dig0_lit"};
    tab[9]  = '{9,  0,  4'b1111, 7'b1111111, 1'b1, "scan2_dig0_dark"};
    tab[10] = '{10, 3,  4'b1101, 7'b0010010, 1'b1, "scan2_dig1_lit"};
    tab[11] = '{13, 8,  4'b1111, 7'b1111111, 1'b1, "scan3_dig0_dark"};
    tab[12] = '{17, 0,  4'b1110, 7'b1001111, 1'b1, "scan4_dig0_lit"};
    tab[13] = '{21, 2,  4'b1110, 7'b1001111, 1'b1, "scan5_dig0_lit"};
    tab[14] = '{25, 2,  4'b1111, 7'b1111111, 1'b1, "scan6_dig0_dark"};

    // Run 1: full scan sequence, brightness 15, blink on digit 0
    digits = {fld(1, 5'd4, 0), fld(1, 5'd3, 0), fld(1, 5'd2, 0), fld(1, 5'd1, 0)};
    blink  = 4'b0001;
    bright = 4'd15;
    repeat (2) @(negedge clock);
    chk("reset_state", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      at(tab[i].slot, tab[i].ph);
      chk(tab[i].name, tab[i].an, tab[i].seg, tab[i].dp);
    end

    // Run 2: brightness 4 gives 8 lit clocks; a mid-slot change to 0 waits for the boundary
    do_reset();
    blink  = 4'b0000;
    bright = 4'd4;
    cnt = 0;
    for (int n = 33; n <= 64; n++) begin
      wait_cyc(n);
      if (an != 4'b1111) cnt++;
      if (n == 40) bright = 4'd0;
    end
    chk_int("bright4_lit_clocks", cnt, 8);
    cnt = 0;
    for (int n = 65; n <= 128; n++) begin
      wait_cyc(n);
      if (an != 4'b1111) cnt++;
    end
    chk_int("bright0_lit_clocks", cnt, 0);

    // Run 3: char codes, en=0, dp, and mid-slot char change
    do_reset();
    bright = 4'd15;
    digits = {fld(0, 5'd4, 0), fld(1, 5'd5, 0), fld(1, 5'h15, 1), fld(1, 5'd0, 0)};
    at(1, 2);
    chk("char0", 4'b1110, 7'b0000001, 1'b1);
    at(2, 3);
    chk("blank_char_dp_on", 4'b1101, 7'b1111111, 1'b0);
    at(3, 2);
    chk("dig2_char5", 4'b1011, 7'b0100100, 1'b1);
    digits[20:14] = fld(1, 5'h11, 0);
    at(3, 10);
    chk("midslot_char_held", 4'b1011, 7'b0100100, 1'b1);
    at(4, 3);
    chk("en0_dark", 4'b1111, 7'b1111111, 1'b1);
    at(7, 2);
    chk("dig2_char_G", 4'b1011, 7'b0100000, 1'b1);

    // Run 4: reset in phase 7 of slot with index 3 blanks at once and restarts at index 0
    do_reset();
    digits = {fld(1, 5'd4, 0), fld(1, 5'd3, 0), fld(1, 5'd2, 0), fld(1, 5'd1, 0)};
    at(4, 7);
    chk("pre_reset_lit", 4'b0111, 7'b1001100, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_reset_blank", 4'b1111, 7'b1111111, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    at(0, 8);
    chk("post_reset_blank", 4'b1111, 7'b1111111, 1'b1);
    at(1, 0);
    chk("post_reset_idx0", 4'b1110, 7'b1001111, 1'b1);
    at(2, 0);
    chk("post_reset_idx1", 4'b1101, 7'b0010010, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
